// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, 1-cycle ROM fetch, 2-entry instruction buffer, branch redirect.
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_stall/perf_redirect counters.
module fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_base,
  input  logic [DATA_WIDTH-1:0] ImmOp
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall,
  output logic [31:0]           perf_redirect
`endif
);

  typedef enum logic [1:0] {S_RUN, S_FULL, S_FLUSH} state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic [1:0]            count, count_nxt, occ;
  logic                  rd_ptr, wr_ptr;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [ADDR_WIDTH-1:0] buf_pc   [2];
  logic                  deq, issue, capture;

  assign instr_valid = (count != 2'd0);
  assign instr       = instr_valid ? buf_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? buf_pc[rd_ptr]   : '0;
  assign imem_req    = issue;
  assign imem_addr   = pc;

  // Issue looks ahead: the slot freed by this cycle's dequeue is usable,
  // the slot reserved by an outstanding response is not.
  always_comb begin
    deq       = instr_valid & instr_ready;
    occ       = count - {1'b0, deq} + {1'b0, inflight};
    issue     = !rst && !redirect && (occ < 2'd2);
    capture   = inflight && !redirect && (state != S_FLUSH);
    count_nxt = count - {1'b0, deq} + {1'b0, capture};
    state_nxt = state;
    if (rst || redirect)
      state_nxt = S_FLUSH;
    else if (count_nxt == 2'd2)
      state_nxt = S_FULL;
    else
      state_nxt = S_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_FLUSH;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (redirect) begin
      // Target wraps modulo 2^ADDR_WIDTH; low bits pass through unaligned.
      pc       <= redirect_base + ADDR_WIDTH'(ImmOp);
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + ADDR_WIDTH'(4);
        inflight_pc <= pc;
      end
      if (capture) begin
        buf_data[wr_ptr] <= imem_rdata;
        buf_pc[wr_ptr]   <= inflight_pc;
        wr_ptr           <= ~wr_ptr;
      end
      if (deq)
        rd_ptr <= ~rd_ptr;
      count <= count_nxt;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched  <= '0;
      perf_stall    <= '0;
      perf_redirect <= '0;
    end else begin
      if (deq)
        perf_fetched <= perf_fetched + 32'd1;
      if (instr_valid && !instr_ready)
        perf_stall <= perf_stall + 32'd1;
      if (redirect)
        perf_redirect <= perf_redirect + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a queue-based delivery model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_base;
  logic [31:0] ImmOp;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, perf_redirect;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_base(redirect_base),
    .ImmOp(ImmOp)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall),
    .perf_redirect(perf_redirect)
`endif
  );

  // ROM: word at A is A|0xA000_0000; unrequested cycles return junk.
  always @(posedge clk)
    imem_rdata <= imem_req ? (imem_addr | 32'hA000_0000) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Model: entries are just PCs in program order; the ROM function gives the data.
  initial begin
    logic [31:0] mq[$];
    logic [31:0] m_pc, m_inf_pc;
    bit          m_inf, after_rst;
    bit          s_rst, s_rdy, s_redir, e_valid, e_deq, e_req;
    logic [31:0] s_base, s_imm;
    m_pc = 32'h0; m_inf_pc = 32'h0; m_inf = 1'b0; after_rst = 1'b0;
    forever begin
      @(negedge clk);
      s_rst = rst; s_rdy = instr_ready; s_redir = redirect;
      s_base = redirect_base; s_imm = ImmOp;
      e_valid = (mq.size() > 0);
      e_deq   = e_valid && s_rdy;
      e_req   = !s_rst && !s_redir && (int'(mq.size()) - int'(e_deq) + int'(m_inf) < 2);
      if (s_rst) begin
        chk("req_in_rst", {31'b0, imem_req}, 32'h0);
      end else begin
        chk("req", {31'b0, imem_req}, {31'b0, e_req});
        if (e_req)
          chk("addr", imem_addr, m_pc);
        chk("valid", {31'b0, instr_valid}, {31'b0, e_valid});
        if (e_valid) begin
          chk("instr_pc", instr_pc, mq[0]);
          chk("instr", instr, mq[0] | 32'hA000_0000);
        end
        if (after_rst) begin
          chk("instr_rst", instr, 32'h0);
          chk("instr_pc_rst", instr_pc, 32'h0);
        end
      end
      @(posedge clk);
      if (s_rst) begin
        mq.delete(); m_inf = 1'b0; m_pc = 32'h0;
      end else if (s_redir) begin
        mq.delete(); m_inf = 1'b0; m_pc = s_base + s_imm;
      end else begin
        if (e_deq)
          void'(mq.pop_front());
        if (m_inf)
          mq.push_back(m_inf_pc);
        m_inf = e_req;
        if (e_req) begin
          m_inf_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
      after_rst = s_rst;
    end
  end

  initial begin
    rst = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    redirect_base = 32'h0; ImmOp = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    while (cyc < 60) begin
      rst = 1'b0; instr_ready = 1'b1; redirect = 1'b0;
      redirect_base = 32'h0; ImmOp = 32'h0;
      if (cyc >= 4 && cyc <= 7) instr_ready = 1'b0;
      if (cyc == 11) begin
        redirect = 1'b1; redirect_base = 32'h10; ImmOp = 32'hFFFF_FFF8; instr_ready = 1'b0;
      end
      if (cyc >= 18 && cyc <= 20) instr_ready = 1'b0;
      if (cyc == 21) begin
        redirect = 1'b1; redirect_base = 32'h20; ImmOp = 32'h40;
      end
      if (cyc == 28) begin
        redirect = 1'b1; redirect_base = 32'hFFFF_FFFC; ImmOp = 32'h8;
      end
      if (cyc == 34) begin
        rst = 1'b1; instr_ready = 1'b0;
      end
      if (cyc >= 38) instr_ready = (cyc % 3 != 0);
      @(negedge clk);
      case (cyc)
        2: begin
          chk("lit_first_instr", instr, 32'hA000_0000);
          chk("lit_first_pc", instr_pc, 32'h0);
        end
        3:  chk("lit_second_pc", instr_pc, 32'h4);
        5: begin
          chk("lit_bp_noreq", {31'b0, imem_req}, 32'h0);
          chk("lit_bp_hold", instr_pc, 32'h8);
        end
        8:  chk("lit_bp_release", instr_pc, 32'h8);
        9:  chk("lit_bp_next", instr_pc, 32'hC);
        11: chk("lit_wrong_head", instr_pc, 32'h14);
        12: begin
          chk("lit_back_req", {31'b0, imem_req}, 32'h1);
          chk("lit_back_addr", imem_addr, 32'h8);
        end
        14: begin
          chk("lit_back_pc", instr_pc, 32'h8);
          chk("lit_back_instr", instr, 32'hA000_0008);
        end
        21: chk("lit_full_valid", {31'b0, instr_valid}, 32'h1);
        22: begin
          chk("lit_flush_empty", {31'b0, instr_valid}, 32'h0);
          chk("lit_fwd_addr", imem_addr, 32'h60);
        end
        24: chk("lit_fwd_pc", instr_pc, 32'h60);
        29: chk("lit_wrap_addr", imem_addr, 32'h4);
        31: chk("lit_wrap_pc", instr_pc, 32'h4);
        35: begin
          chk("lit_rst_valid", {31'b0, instr_valid}, 32'h0);
          chk("lit_rst_instr", instr, 32'h0);
          chk("lit_rst_req", {31'b0, imem_req}, 32'h1);
          chk("lit_rst_addr", imem_addr, 32'h0);
        end
        37: begin
          chk("lit_restart_pc", instr_pc, 32'h0);
          chk("lit_restart_instr", instr, 32'hA000_0000);
        end
        default: ;
      endcase
      @(posedge clk);
      #1;
      cyc++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
